legv8_control_unit: RTL and testbench

Multi-cycle control sequencer for the LEGv8 datapath/memory system. Drives the 34-bit control word and the 64-bit constant into the datapath wrapper, and consumes its instruction-register and status outputs. Runs a FETCH/EXECUTE state machine over a fixed LEGv8 subset. Enters a sticky HALT state on any undefined opcode.

---
 rtl/legv8_ctrl_pkg.sv | 157 +++++++++++++++
 rtl/legv8_control_unit_cond_eval.sv | 41 ++++
 rtl/legv8_control_unit.sv | 192 +++++++++++++++++++
 tb/tb_legv8_control_unit.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/legv8_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : legv8_ctrl_pkg
// Description : Shared types, encodings and helpers for the LEGv8 control unit.
// Revision    : 1.0 - initial release
// ============================================================================
package legv8_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_EX0   = 3'd1,
        ST_EX1   = 3'd2,
        ST_HALT  = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_EOR, OP_ADDI, OP_SUBI, OP_MOVZ,
        OP_LDUR, OP_STUR, OP_B, OP_BCOND, OP_CBZ, OP_CBNZ, OP_BL, OP_UNDEF
    } op_t;

    // Opcodes, each sized to the number of IR MSBs that identify it
    localparam logic [10:0] C_OPC_ADD   = 11'b10001011000;
    localparam logic [10:0] C_OPC_SUB   = 11'b11001011000;
    localparam logic [10:0] C_OPC_AND   = 11'b10001010000;
    localparam logic [10:0] C_OPC_ORR   = 11'b10101010000;
    localparam logic [10:0] C_OPC_EOR   = 11'b11001010000;
    localparam logic [9:0]  C_OPC_ADDI  = 10'b1001000100;
    localparam logic [9:0]  C_OPC_SUBI  = 10'b1101000100;
    localparam logic [8:0]  C_OPC_MOVZ  = 9'b110100101;
    localparam logic [10:0] C_OPC_LDUR  = 11'b11111000010;
    localparam logic [10:0] C_OPC_STUR  = 11'b11111000000;
    localparam logic [5:0]  C_OPC_B     = 6'b000101;
    localparam logic [7:0]  C_OPC_BCOND = 8'b01010100;
    localparam logic [7:0]  C_OPC_CBZ   = 8'b10110100;
    localparam logic [7:0]  C_OPC_CBNZ  = 8'b10110101;
    localparam logic [5:0]  C_OPC_BL    = 6'b100101;

    localparam logic [4:0] C_FS_AND    = 5'b00000;
    localparam logic [4:0] C_FS_ORR    = 5'b00100;
    localparam logic [4:0] C_FS_ADD    = 5'b01000;
    localparam logic [4:0] C_FS_SUB    = 5'b01001;
    localparam logic [4:0] C_FS_EOR    = 5'b01100;
    localparam logic [4:0] C_FS_PASS_A = 5'b10000;
    localparam logic [4:0] C_FS_PASS_B = 5'b10100;

    localparam logic [1:0] C_DS_ALU  = 2'b00;
    localparam logic [1:0] C_DS_REGB = 2'b01;
    localparam logic [1:0] C_DS_PC   = 2'b10;
    localparam logic [1:0] C_DS_MEM  = 2'b11;

    localparam logic [1:0] C_PS_HOLD   = 2'b00;
    localparam logic [1:0] C_PS_INC    = 2'b01;
    localparam logic [1:0] C_PS_BRANCH = 2'b10;

    localparam logic [1:0] C_SIZE_DWORD = 2'b11;
    localparam logic [4:0] C_REG_ZR     = 5'd31;
    localparam logic [4:0] C_REG_LR     = 5'd30;

    localparam logic [3:0] C_COND_EQ = 4'b0000;
    localparam logic [3:0] C_COND_NE = 4'b0001;
    localparam logic [3:0] C_COND_HS = 4'b0010;
    localparam logic [3:0] C_COND_LO = 4'b0011;
    localparam logic [3:0] C_COND_MI = 4'b0100;
    localparam logic [3:0] C_COND_PL = 4'b0101;
    localparam logic [3:0] C_COND_VS = 4'b0110;
    localparam logic [3:0] C_COND_VC = 4'b0111;
    localparam logic [3:0] C_COND_HI = 4'b1000;
    localparam logic [3:0] C_COND_LS = 4'b1001;
    localparam logic [3:0] C_COND_GE = 4'b1010;
    localparam logic [3:0] C_COND_LT = 4'b1011;
    localparam logic [3:0] C_COND_GT = 4'b1100;
    localparam logic [3:0] C_COND_LE = 4'b1101;

    // ControlWord bit offsets (LSB of each field)
    localparam int C_CW_WIDTH = 34;
    localparam int C_CW_SB    = 0;
    localparam int C_CW_SA    = 5;
    localparam int C_CW_DA    = 10;
    localparam int C_CW_RW    = 15;
    localparam int C_CW_MW    = 16;
    localparam int C_CW_SIZE  = 17;
    localparam int C_CW_C0    = 19;
    localparam int C_CW_FS    = 20;
    localparam int C_CW_SL    = 25;
    localparam int C_CW_IL    = 26;
    localparam int C_CW_BSEL  = 27;
    localparam int C_CW_PCSEL = 28;
    localparam int C_CW_PS    = 29;
    localparam int C_CW_DS    = 31;
    localparam int C_CW_AS    = 33;

    typedef struct packed {
        logic       as;
        logic [1:0] ds;
        logic [1:0] ps;
        logic       pcsel;
        logic       bsel;
        logic       il;
        logic       sl;
        logic [4:0] fs;
        logic       c0;
        logic [1:0] size;
        logic       mw;
        logic       rw;
        logic [4:0] da;
        logic [4:0] sa;
        logic [4:0] sb;
    } ctrl_word_t;

    function automatic ctrl_word_t cw_default();
        ctrl_word_t cw;
        cw      = '0;
        cw.as   = 1'b1;
        cw.ds   = C_DS_ALU;
        cw.ps   = C_PS_HOLD;
        cw.size = C_SIZE_DWORD;
        cw.da   = C_REG_ZR;
        cw.sa   = C_REG_ZR;
        cw.sb   = C_REG_ZR;
        return cw;
    endfunction

    function automatic op_t decode_op(input logic [10:0] opc);
        op_t op;
        op = OP_UNDEF;
        if      (opc == C_OPC_ADD)          op = OP_ADD;
        else if (opc == C_OPC_SUB)          op = OP_SUB;
        else if (opc == C_OPC_AND)          op = OP_AND;
        else if (opc == C_OPC_ORR)          op = OP_ORR;
        else if (opc == C_OPC_EOR)          op = OP_EOR;
        else if (opc == C_OPC_LDUR)         op = OP_LDUR;
        else if (opc == C_OPC_STUR)         op = OP_STUR;
        else if (opc[10:1] == C_OPC_ADDI)   op = OP_ADDI;
        else if (opc[10:1] == C_OPC_SUBI)   op = OP_SUBI;
        else if (opc[10:2] == C_OPC_MOVZ)   op = OP_MOVZ;
        else if (opc[10:3] == C_OPC_BCOND)  op = OP_BCOND;
        else if (opc[10:3] == C_OPC_CBZ)    op = OP_CBZ;
        else if (opc[10:3] == C_OPC_CBNZ)   op = OP_CBNZ;
        else if (opc[10:5] == C_OPC_B)      op = OP_B;
        else if (opc[10:5] == C_OPC_BL)     op = OP_BL;
        return op;
    endfunction

    function automatic logic [4:0] alu_fs(input op_t op);
        logic [4:0] fs;
        case (op)
            OP_SUB, OP_SUBI: fs = C_FS_SUB;
            OP_AND:          fs = C_FS_AND;
            OP_ORR:          fs = C_FS_ORR;
            OP_EOR:          fs = C_FS_EOR;
            default:         fs = C_FS_ADD;
        endcase
        return fs;
    endfunction

endpackage
`default_nettype wire

// File: rtl/legv8_control_unit_cond_eval.sv
`default_nettype none
// ============================================================================
// Module      : legv8_cond_eval
// Description : Evaluates a B.cond condition code against {V,C,N,Z}.
// Revision    : 1.0 - initial release
// ============================================================================
module legv8_cond_eval
    import legv8_ctrl_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [3:0] i_flags,
    output logic       o_take
);

    logic w_v, w_c, w_n, w_z;
    assign {w_v, w_c, w_n, w_z} = i_flags;

    // Codes 1110 and 1111 both fall through to always-taken
    always_comb begin
        o_take = 1'b1;
        case (i_cond)
            C_COND_EQ: o_take = w_z;
            C_COND_NE: o_take = ~w_z;
            C_COND_HS: o_take = w_c;
            C_COND_LO: o_take = ~w_c;
            C_COND_MI: o_take = w_n;
            C_COND_PL: o_take = ~w_n;
            C_COND_VS: o_take = w_v;
            C_COND_VC: o_take = ~w_v;
            C_COND_HI: o_take = w_c & ~w_z;
            C_COND_LS: o_take = ~(w_c & ~w_z);
            C_COND_GE: o_take = (w_n == w_v);
            C_COND_LT: o_take = (w_n != w_v);
            C_COND_GT: o_take = ~w_z & (w_n == w_v);
            C_COND_LE: o_take = ~(~w_z & (w_n == w_v));
            default:   o_take = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/legv8_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : legv8_control_unit
// Description : Multi-cycle FETCH/EXECUTE sequencer driving the LEGv8 datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module legv8_control_unit
    import legv8_ctrl_pkg::*;
#(
    parameter int PC_STEP_ADJ = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] IR_out,
    input  logic [4:0]  status,
    output logic [33:0] ControlWord,
    output logic [63:0] constant,
    output logic [2:0]  state,
    output logic        halted
);

    localparam logic [63:0] C_ADJ = 64'(PC_STEP_ADJ);

    state_t     r_state;
    state_t     w_next_state;
    logic       r_zflag;
    logic       w_latch_z;
    op_t        w_op;
    ctrl_word_t w_cw;
    logic [63:0] w_const;
    logic        w_cond_take;

    logic [4:0]  w_rd, w_rn, w_rm;
    logic [63:0] w_imm12, w_imm9, w_movz, w_br26, w_br19;

    assign w_op = decode_op(IR_out[31:21]);
    assign w_rd = IR_out[4:0];
    assign w_rn = IR_out[9:5];
    assign w_rm = IR_out[20:16];

    assign w_imm12 = {52'd0, IR_out[21:10]};
    assign w_imm9  = {{55{IR_out[20]}}, IR_out[20:12]};
    assign w_movz  = {48'd0, IR_out[20:5]} << {IR_out[22:21], 4'b0000};
    // PC has already advanced at FETCH, so branch offsets are pulled back
    assign w_br26  = {{38{IR_out[25]}}, IR_out[25:0]} - C_ADJ;
    assign w_br19  = {{45{IR_out[23]}}, IR_out[23:5]} - C_ADJ;

    legv8_cond_eval u_cond_eval (
        .i_cond  (IR_out[3:0]),
        .i_flags (status[4:1]),
        .o_take  (w_cond_take)
    );

    always_comb begin
        w_cw         = cw_default();
        w_const      = '0;
        w_next_state = r_state;
        w_latch_z    = 1'b0;
        case (r_state)
            ST_FETCH: begin
                w_cw.ds      = C_DS_MEM;
                w_cw.il      = 1'b1;
                w_cw.ps      = C_PS_INC;
                w_next_state = ST_EX0;
            end
            ST_EX0: begin
                w_next_state = ST_FETCH;
                case (w_op)
                    OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_EOR, OP_ADDI, OP_SUBI: begin
                        w_cw.sa   = w_rn;
                        w_cw.sb   = w_rm;
                        w_cw.da   = w_rd;
                        w_cw.rw   = 1'b1;
                        w_cw.fs   = alu_fs(w_op);
                        w_cw.c0   = (w_op == OP_SUB) || (w_op == OP_SUBI);
                        w_cw.sl   = (w_op == OP_SUB) || (w_op == OP_SUBI);
                        w_cw.bsel = (w_op == OP_ADDI) || (w_op == OP_SUBI);
                        if (w_cw.bsel) begin
                            w_const = w_imm12;
                        end
                    end
                    OP_MOVZ: begin
                        w_const   = w_movz;
                        w_cw.fs   = C_FS_PASS_B;
                        w_cw.bsel = 1'b1;
                        w_cw.rw   = 1'b1;
                        w_cw.da   = w_rd;
                    end
                    OP_LDUR, OP_STUR: begin
                        w_const   = w_imm9;
                        w_cw.sa   = w_rn;
                        w_cw.fs   = C_FS_ADD;
                        w_cw.bsel = 1'b1;
                        w_cw.as   = 1'b0;
                        if (w_op == OP_LDUR) begin
                            w_cw.ds = C_DS_MEM;
                            w_cw.rw = 1'b1;
                            w_cw.da = w_rd;
                        end else begin
                            w_cw.ds = C_DS_REGB;
                            w_cw.mw = 1'b1;
                            w_cw.sb = w_rd;
                        end
                    end
                    OP_B: begin
                        w_cw.ps    = C_PS_BRANCH;
                        w_cw.pcsel = 1'b1;
                        w_const    = w_br26;
                    end
                    OP_BCOND: begin
                        if (w_cond_take) begin
                            w_cw.ps    = C_PS_BRANCH;
                            w_cw.pcsel = 1'b1;
                            w_const    = w_br19;
                        end
                    end
                    OP_CBZ, OP_CBNZ: begin
                        w_cw.sa      = w_rd;
                        w_cw.fs      = C_FS_PASS_A;
                        w_latch_z    = 1'b1;
                        w_next_state = ST_EX1;
                    end
                    OP_BL: begin
                        w_cw.ds      = C_DS_PC;
                        w_cw.rw      = 1'b1;
                        w_cw.da      = C_REG_LR;
                        w_next_state = ST_EX1;
                    end
                    default: w_next_state = ST_HALT;
                endcase
            end
            ST_EX1: begin
                w_next_state = ST_FETCH;
                if (w_op == OP_BL) begin
                    w_cw.ps    = C_PS_BRANCH;
                    w_cw.pcsel = 1'b1;
                    w_const    = w_br26;
                end else if ((w_op == OP_CBZ && r_zflag) || (w_op == OP_CBNZ && !r_zflag)) begin
                    w_cw.ps    = C_PS_BRANCH;
                    w_cw.pcsel = 1'b1;
                    w_const    = w_br19;
                end
            end
            ST_HALT: w_next_state = ST_HALT;
            default: w_next_state = ST_FETCH;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_FETCH;
            r_zflag <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_latch_z) begin
                r_zflag <= status[0];
            end
        end
    end

    // Outputs are forced quiet while reset is held so no write strobe escapes
    always_comb begin
        ControlWord = '0;
        constant    = '0;
        if (!reset) begin
            ControlWord[C_CW_AS]          = w_cw.as;
            ControlWord[C_CW_DS +: 2]     = w_cw.ds;
            ControlWord[C_CW_PS +: 2]     = w_cw.ps;
            ControlWord[C_CW_PCSEL]       = w_cw.pcsel;
            ControlWord[C_CW_BSEL]        = w_cw.bsel;
            ControlWord[C_CW_IL]          = w_cw.il;
            ControlWord[C_CW_SL]          = w_cw.sl;
            ControlWord[C_CW_FS +: 5]     = w_cw.fs;
            ControlWord[C_CW_C0]          = w_cw.c0;
            ControlWord[C_CW_SIZE +: 2]   = w_cw.size;
            ControlWord[C_CW_MW]          = w_cw.mw;
            ControlWord[C_CW_RW]          = w_cw.rw;
            ControlWord[C_CW_DA +: 5]     = w_cw.da;
            ControlWord[C_CW_SA +: 5]     = w_cw.sa;
            ControlWord[C_CW_SB +: 5]     = w_cw.sb;
            constant                      = w_const;
        end
    end

    assign state  = r_state;
    assign halted = !reset && (r_state == ST_HALT);

    logic [C_CW_WIDTH-1:0] w_unused_width_ref;
    assign w_unused_width_ref = ControlWord;

endmodule
`default_nettype wire

// File: tb/tb_legv8_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_legv8_control_unit
// Description : Directed and randomized self-checking bench for the control unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_legv8_control_unit;

    localparam int PC_STEP_ADJ = 1;

    localparam int K_ADD = 0, K_SUB = 1, K_AND = 2, K_ORR = 3, K_EOR = 4, K_ADDI = 5,
                   K_SUBI = 6, K_MOVZ = 7, K_LDUR = 8, K_STUR = 9, K_B = 10, K_BCOND = 11,
                   K_CBZ = 12, K_CBNZ = 13, K_BL = 14, K_UNDEF = 15;

    localparam logic [33:0] C_DEFAULT_CW = {1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0,
                                            5'b00000, 1'b0, 2'b11, 1'b0, 1'b0,
                                            5'd31, 5'd31, 5'd31};

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] IR_out = '0;
    logic [4:0]  status = '0;
    logic [33:0] ControlWord;
    logic [63:0] constant;
    logic [2:0]  state;
    logic        halted;

    int   n_total = 0;
    int   n_bad   = 0;
    logic m_zflag = 1'b0;

    legv8_control_unit #(.PC_STEP_ADJ(PC_STEP_ADJ)) dut (
        .clock       (clock),
        .reset       (reset),
        .IR_out      (IR_out),
        .status      (status),
        .ControlWord (ControlWord),
        .constant    (constant),
        .state       (state),
        .halted      (halted)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 2 ns later
    task automatic tick(input logic rst, input logic [31:0] ir, input logic [4:0] st);
        @(negedge clock);
        reset  = rst;
        IR_out = ir;
        status = st;
        #2;
    endtask

    function automatic int kind_of(input logic [31:0] ir);
        casez (ir[31:21])
            11'b10001011000: return K_ADD;
            11'b11001011000: return K_SUB;
            11'b10001010000: return K_AND;
            11'b10101010000: return K_ORR;
            11'b11001010000: return K_EOR;
            11'b11111000010: return K_LDUR;
            11'b11111000000: return K_STUR;
            11'b1001000100?: return K_ADDI;
            11'b1101000100?: return K_SUBI;
            11'b110100101??: return K_MOVZ;
            11'b01010100???: return K_BCOND;
            11'b10110100???: return K_CBZ;
            11'b10110101???: return K_CBNZ;
            11'b000101?????: return K_B;
            11'b100101?????: return K_BL;
            default:         return K_UNDEF;
        endcase
    endfunction

    function automatic logic [31:0] rand_instr(input int kd);
        logic [31:0] r;
        r = $urandom;
        case (kd)
            K_ADD:   r[31:21] = 11'b10001011000;
            K_SUB:   r[31:21] = 11'b11001011000;
            K_AND:   r[31:21] = 11'b10001010000;
            K_ORR:   r[31:21] = 11'b10101010000;
            K_EOR:   r[31:21] = 11'b11001010000;
            K_ADDI:  r[31:22] = 10'b1001000100;
            K_SUBI:  r[31:22] = 10'b1101000100;
            K_MOVZ:  r[31:23] = 9'b110100101;
            K_LDUR:  r[31:21] = 11'b11111000010;
            K_STUR:  r[31:21] = 11'b11111000000;
            K_B:     r[31:26] = 6'b000101;
            K_BCOND: r[31:24] = 8'b01010100;
            K_CBZ:   r[31:24] = 8'b10110100;
            K_CBNZ:  r[31:24] = 8'b10110101;
            default: r[31:26] = 6'b100101;
        endcase
        return r;
    endfunction

    function automatic longint sx(input longint v, input int bits);
        if (v >= (longint'(1) << (bits - 1))) return v - (longint'(1) << bits);
        return v;
    endfunction

    // ARM rule: pairs of codes share a base test, odd codes invert it, 111x always
    function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] f);
        logic v, c, n, z, base;
        {v, c, n, z} = f;
        case (cond[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (cond[3:1] != 3'd7 && cond[0]) return !base;
        return base;
    endfunction

    function automatic void model(input logic [31:0] ir, input int phase, input logic [4:0] st,
                                  input logic zf, output logic [33:0] cw, output logic [63:0] k);
        logic a, pcs, bs, il, sl, c0, mw, rw;
        logic [1:0] ds, ps, sz;
        logic [4:0] fs, da, sa, sb;
        int kd;
        kd = kind_of(ir);
        a = 1; ds = 0; ps = 0; pcs = 0; bs = 0; il = 0; sl = 0; fs = 0; c0 = 0;
        sz = 2'b11; mw = 0; rw = 0; da = 31; sa = 31; sb = 31; k = 0;
        if (phase == 0) begin
            ds = 2'b11; il = 1; ps = 2'b01;
        end else if (phase == 1) begin
            case (kd)
                K_ADD, K_SUB, K_AND, K_ORR, K_EOR, K_ADDI, K_SUBI: begin
                    sa = ir[9:5]; sb = ir[20:16]; da = ir[4:0]; rw = 1;
                    case (kd)
                        K_ADD, K_ADDI: fs = 5'b01000;
                        K_SUB, K_SUBI: begin fs = 5'b01001; c0 = 1; sl = 1; end
                        K_AND:         fs = 5'b00000;
                        K_ORR:         fs = 5'b00100;
                        default:       fs = 5'b01100;
                    endcase
                    if (kd == K_ADDI || kd == K_SUBI) begin
                        bs = 1; k = 64'(ir[21:10]);
                    end
                end
                K_MOVZ: begin
                    k = 64'(ir[20:5]) << (16 * ir[22:21]);
                    fs = 5'b10100; bs = 1; rw = 1; da = ir[4:0];
                end
                K_LDUR: begin
                    sa = ir[9:5]; k = 64'(sx(64'(ir[20:12]), 9)); fs = 5'b01000; bs = 1;
                    a = 0; ds = 2'b11; rw = 1; da = ir[4:0];
                end
                K_STUR: begin
                    sa = ir[9:5]; k = 64'(sx(64'(ir[20:12]), 9)); fs = 5'b01000; bs = 1;
                    a = 0; ds = 2'b01; mw = 1; sb = ir[4:0];
                end
                K_B: begin
                    ps = 2'b10; pcs = 1; k = 64'(sx(64'(ir[25:0]), 26) - PC_STEP_ADJ);
                end
                K_BCOND: begin
                    if (cond_holds(ir[3:0], st[4:1])) begin
                        ps = 2'b10; pcs = 1; k = 64'(sx(64'(ir[23:5]), 19) - PC_STEP_ADJ);
                    end
                end
                K_CBZ, K_CBNZ: begin
                    sa = ir[4:0]; fs = 5'b10000;
                end
                K_BL: begin
                    ds = 2'b10; rw = 1; da = 5'd30;
                end
                default: ;
            endcase
        end else begin
            if (kd == K_BL) begin
                ps = 2'b10; pcs = 1; k = 64'(sx(64'(ir[25:0]), 26) - PC_STEP_ADJ);
            end else if ((kd == K_CBZ && zf) || (kd == K_CBNZ && !zf)) begin
                ps = 2'b10; pcs = 1; k = 64'(sx(64'(ir[23:5]), 19) - PC_STEP_ADJ);
            end
        end
        cw = {a, ds, ps, pcs, bs, il, sl, fs, c0, sz, mw, rw, da, sa, sb};
    endfunction

    task automatic run_instr(input logic [31:0] ir);
        logic [33:0] ecw;
        logic [63:0] ek;
        logic [4:0]  st;
        int kd, ncyc;
        kd   = kind_of(ir);
        ncyc = (kd == K_CBZ || kd == K_CBNZ || kd == K_BL) ? 3 : 2;
        for (int ph = 0; ph < ncyc; ph++) begin
            st = 5'($urandom);
            tick(1'b0, ir, st);
            model(ir, ph, st, m_zflag, ecw, ek);
            check($sformatf("cw k%0d p%0d ir=%h", kd, ph, ir), 64'(ControlWord), 64'(ecw));
            check($sformatf("const k%0d p%0d ir=%h", kd, ph, ir), constant, ek);
            check($sformatf("state k%0d p%0d", kd, ph), 64'(state), 64'(ph));
            check($sformatf("halted k%0d p%0d", kd, ph), 64'(halted), 64'd0);
            if (ph == 1 && (kd == K_CBZ || kd == K_CBNZ)) m_zflag = st[0];
        end
    endtask

    initial begin
        // Reset behaviour
        tick(1'b1, 32'h0, 5'h0);
        tick(1'b1, 32'h8B030041, 5'h0);
        check("rst_cw", 64'(ControlWord), 64'd0);
        check("rst_const", constant, 64'd0);
        check("rst_halted", 64'(halted), 64'd0);

        // ADD X1,X2,X3
        tick(1'b0, 32'h8B030041, 5'h0);
        check("fetch_state", 64'(state), 64'd0);
        check("fetch_as", 64'(ControlWord[33]), 64'd1);
        check("fetch_ds", 64'(ControlWord[32:31]), 64'd3);
        check("fetch_il", 64'(ControlWord[26]), 64'd1);
        check("fetch_ps", 64'(ControlWord[30:29]), 64'd1);
        tick(1'b0, 32'h8B030041, 5'h0);
        check("add_sa", 64'(ControlWord[9:5]), 64'd2);
        check("add_sb", 64'(ControlWord[4:0]), 64'd3);
        check("add_da", 64'(ControlWord[14:10]), 64'd1);
        check("add_rw", 64'(ControlWord[15]), 64'd1);
        check("add_fs", 64'(ControlWord[24:20]), 64'b01000);

        // LDUR X5,[X6,#-8]
        tick(1'b0, 32'hF85F80C5, 5'h0);
        tick(1'b0, 32'hF85F80C5, 5'h0);
        check("ldur_const", constant, 64'hFFFF_FFFF_FFFF_FFF8);
        check("ldur_as", 64'(ControlWord[33]), 64'd0);
        check("ldur_ds", 64'(ControlWord[32:31]), 64'd3);
        check("ldur_rw", 64'(ControlWord[15]), 64'd1);
        check("ldur_da", 64'(ControlWord[14:10]), 64'd5);

        // STUR X5,[X6,#16]
        tick(1'b0, 32'hF80100C5, 5'h0);
        tick(1'b0, 32'hF80100C5, 5'h0);
        check("stur_mw", 64'(ControlWord[16]), 64'd1);
        check("stur_ds", 64'(ControlWord[32:31]), 64'd1);
        check("stur_sb", 64'(ControlWord[4:0]), 64'd5);
        check("stur_rw", 64'(ControlWord[15]), 64'd0);

        // CBZ X4,+3 taken, then not taken
        tick(1'b0, 32'hB4000064, 5'h0);
        tick(1'b0, 32'hB4000064, 5'h1);
        tick(1'b0, 32'hB4000064, 5'h0);
        check("cbz_t_ps", 64'(ControlWord[30:29]), 64'd2);
        check("cbz_t_pcsel", 64'(ControlWord[28]), 64'd1);
        check("cbz_t_const", constant, 64'd2);
        tick(1'b0, 32'hB4000064, 5'h1);
        tick(1'b0, 32'hB4000064, 5'h0);
        tick(1'b0, 32'hB4000064, 5'h1);
        check("cbz_nt_ps", 64'(ControlWord[30:29]), 64'd0);
        m_zflag = 1'b0;

        // B.GT +5 taken, then not taken with Z set
        tick(1'b0, 32'h540000AC, 5'h0);
        tick(1'b0, 32'h540000AC, 5'b00000);
        check("bgt_t_ps", 64'(ControlWord[30:29]), 64'd2);
        check("bgt_t_const", constant, 64'd4);
        tick(1'b0, 32'h540000AC, 5'h0);
        tick(1'b0, 32'h540000AC, 5'b00010);
        check("bgt_nt_ps", 64'(ControlWord[30:29]), 64'd0);

        // BL -2
        tick(1'b0, 32'h97FFFFFE, 5'h0);
        tick(1'b0, 32'h97FFFFFE, 5'h0);
        check("bl_da", 64'(ControlWord[14:10]), 64'd30);
        check("bl_ds", 64'(ControlWord[32:31]), 64'd2);
        check("bl_rw", 64'(ControlWord[15]), 64'd1);
        tick(1'b0, 32'h97FFFFFE, 5'h0);
        check("bl_const", constant, 64'hFFFF_FFFF_FFFF_FFFD);

        // Reset asserted during STUR execute suppresses the store strobe
        tick(1'b0, 32'hF80100C5, 5'h0);
        tick(1'b1, 32'hF80100C5, 5'h0);
        check("midrst_cw", 64'(ControlWord), 64'd0);
        m_zflag = 1'b0;
        run_instr(32'h8B030041);

        // Randomized instruction stream against the reference model
        for (int i = 0; i < 200; i++) begin
            run_instr(rand_instr(int'($urandom_range(0, 14))));
        end

        // Undefined opcode enters sticky HALT
        tick(1'b0, 32'h0, 5'h0);
        tick(1'b0, 32'h0, 5'h0);
        check("undef_ex0_cw", 64'(ControlWord), 64'(C_DEFAULT_CW));
        check("undef_ex0_state", 64'(state), 64'd1);
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, $urandom, 5'($urandom));
            check($sformatf("halt_state %0d", i), 64'(state), 64'd7);
            check($sformatf("halt_flag %0d", i), 64'(halted), 64'd1);
            check($sformatf("halt_cw %0d", i), 64'(ControlWord), 64'(C_DEFAULT_CW));
        end
        tick(1'b1, 32'h0, 5'h0);
        check("halt_rst_halted", 64'(halted), 64'd0);
        tick(1'b0, 32'h8B030041, 5'h0);
        check("post_halt_state", 64'(state), 64'd0);
        check("post_halt_il", 64'(ControlWord[26]), 64'd1);
        check("post_halt_halted", 64'(halted), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
